// File: rtl/boost_pi_ctrl.sv
// Boost converter PI voltage loop: soft-start reference, clamped
// integrator, clamped duty output and latched over-voltage trip.
module boost_pi_ctrl #(
  parameter int KP        = 4,
  parameter int KI        = 1,
  parameter int SHIFT     = 6,
  parameter int DMAX      = 90,
  parameter int DMIN      = 0,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_DIV  = 4,
  parameter int VOV_LIM   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [9:0] vref,
  input  logic [9:0] vfb,
  input  logic       vfb_valid,
  output logic [9:0] d,
  output logic       d_valid,
  output logic       busy,
  output logic       fault
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);
  localparam logic [10:0] STEP = 11'(RAMP_STEP);
  localparam logic [9:0] STEP10 = 10'(RAMP_STEP);
  localparam logic [10:0] VOV = 11'(VOV_LIM);
  localparam logic signed [19:0] KP_S = 20'(KP);
  localparam logic signed [19:0] KI_S = 20'(KI);
  localparam logic signed [24:0] IMAX = 25'(DMAX << SHIFT);
  localparam logic signed [24:0] UMAX = 25'(DMAX);
  localparam logic signed [24:0] UMIN = 25'(DMIN);

  typedef enum logic [1:0] {IDLE, ERR, INTEG, OUT} state_e;

  state_e state_q;
  logic [9:0] vfb_q;
  logic [9:0] vref_eff_q;
  logic [CW-1:0] cnt_q;
  logic signed [10:0] err_q;
  logic signed [23:0] integ_q;
  logic [9:0] d_q;
  logic d_valid_q;
  logic busy_q;
  logic fault_q;

  logic trip;
  logic signed [10:0] err_d;
  logic signed [10:0] rdiff;
  logic [10:0] rmag;
  logic [9:0] vref_eff_d;
  logic [CW-1:0] cnt_d;
  logic signed [19:0] err_x;
  logic signed [19:0] kp_prod;
  logic signed [19:0] ki_prod;
  logic signed [24:0] isum;
  logic signed [23:0] integ_d;
  logic signed [24:0] pi_sum;
  logic signed [24:0] u;
  logic [9:0] d_d;

  assign trip = en && vfb_valid && !fault_q && ({1'b0, vfb} >= VOV);

  always_comb begin
    err_d = $signed({1'b0, vref_eff_q}) - $signed({1'b0, vfb_q});
    rdiff = $signed({1'b0, vref}) - $signed({1'b0, vref_eff_q});
    rmag = rdiff[10] ? $unsigned(-rdiff) : $unsigned(rdiff);
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    vref_eff_d = vref_eff_q;
    // Snap once within one step so the ramp never overshoots vref.
    if (rmag <= STEP) begin
      vref_eff_d = vref;
    end else if (cnt_q == CNT_LAST) begin
      vref_eff_d = rdiff[10] ? vref_eff_q - STEP10
                             : vref_eff_q + STEP10;
    end
    err_x = {{9{err_q[10]}}, err_q};
    kp_prod = err_x * KP_S;
    ki_prod = err_x * KI_S;
    isum = $signed({integ_q[23], integ_q})
         + $signed({{5{ki_prod[19]}}, ki_prod});
    if (isum < 0) integ_d = '0;
    else if (isum > IMAX) integ_d = IMAX[23:0];
    else integ_d = isum[23:0];
    pi_sum = $signed({{5{kp_prod[19]}}, kp_prod})
           + $signed({integ_q[23], integ_q});
    u = pi_sum >>> SHIFT;
    if (u < UMIN) d_d = UMIN[9:0];
    else if (u > UMAX) d_d = UMAX[9:0];
    else d_d = u[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vfb_q      <= '0;
      vref_eff_q <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      integ_q    <= '0;
      d_q        <= '0;
      d_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      d_valid_q <= 1'b0;
      if (!en) begin
        state_q    <= IDLE;
        vref_eff_q <= '0;
        cnt_q      <= '0;
        integ_q    <= '0;
        d_q        <= '0;
        busy_q     <= 1'b0;
        fault_q    <= 1'b0;
      end else if (trip) begin
        fault_q   <= 1'b1;
        d_q       <= '0;
        d_valid_q <= 1'b1;
        integ_q   <= '0;
        busy_q    <= 1'b0;
        state_q   <= IDLE;
      end else if (!fault_q) begin
        case (state_q)
          IDLE: begin
            if (vfb_valid) begin
              vfb_q   <= vfb;
              busy_q  <= 1'b1;
              state_q <= ERR;
            end
          end
          ERR: begin
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            vref_eff_q <= vref_eff_d;
            state_q    <= INTEG;
          end
          INTEG: begin
            integ_q <= integ_d;
            state_q <= OUT;
          end
          OUT: begin
            d_q       <= d_d;
            d_valid_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign d       = d_q;
  assign d_valid = d_valid_q;
  assign busy    = busy_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_boost_pi_ctrl.sv
// Directed bench for boost_pi_ctrl: a fast-ramp instance for the PI
// math and a default instance for the soft-start reference ramp.
module tb_boost_pi_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic vfb_valid = 1'b0;
  logic [9:0] vref = '0;
  logic [9:0] vfb = '0;
  logic [9:0] d_f, d_s;
  logic dv_f, dv_s, busy_f, busy_s, fault_f, fault_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  boost_pi_ctrl #(.RAMP_STEP(1023)) u_fast (
    .clk(clk), .rst_n(rst_n), .en(en), .vref(vref), .vfb(vfb),
    .vfb_valid(vfb_valid), .d(d_f), .d_valid(dv_f), .busy(busy_f),
    .fault(fault_f)
  );

  boost_pi_ctrl u_soft (
    .clk(clk), .rst_n(rst_n), .en(en), .vref(vref), .vfb(vfb),
    .vfb_valid(vfb_valid), .d(d_s), .d_valid(dv_s), .busy(busy_s),
    .fault(fault_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [9:0] v);
    vfb = v;
    vfb_valid = 1'b1;
    tick();
    vfb_valid = 1'b0;
  endtask

  task automatic sample(input logic [9:0] v, output int lat);
    strobe(v);
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      tick();
      if (dv_f) lat = i;
    end
  endtask

  task automatic en_cycle();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    int lat;
    en = 1'b1;
    vref = 10'd200;
    repeat (2) tick();
    checks++;
    if ({d_f, dv_f, busy_f, fault_f} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0",
               {d_f, dv_f, busy_f, fault_f});
    end
    rst_n = 1'b1;
    tick();
    strobe(10'd100);
    tick();
    checks++;
    if (busy_f !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy_pre got=%b exp=1", busy_f);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({d_f, dv_f, busy_f, fault_f} !== 13'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0",
               {d_f, dv_f, busy_f, fault_f});
    end
    #1 rst_n = 1'b1;
    tick();
    sample(10'd100, lat);
    checks++;
    if (lat !== 3 || d_f !== 10'd0) begin
      failures++;
      $display("FAIL post_reset_sample lat=%0d d=%0d exp lat=3 d=0",
               lat, d_f);
    end
  endtask

  task automatic test_basic_pi();
    vref = 10'd200;
    strobe(10'd100);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_f !== 1'b1 || dv_f !== 1'b0) begin
        failures++;
        $display("FAIL basic_busy[%0d] busy=%b dv=%b exp busy=1 dv=0",
                 i, busy_f, dv_f);
      end
      tick();
    end
    checks++;
    if (dv_f !== 1'b1 || d_f !== 10'd7 || busy_f !== 1'b0) begin
      failures++;
      $display("FAIL basic_out dv=%b d=%0d busy=%b exp dv=1 d=7 busy=0",
               dv_f, d_f, busy_f);
    end
    tick();
    checks++;
    if (dv_f !== 1'b0 || d_f !== 10'd7) begin
      failures++;
      $display("FAIL basic_hold dv=%b d=%0d exp dv=0 d=7", dv_f, d_f);
    end
  endtask

  task automatic test_saturation();
    int lat;
    int exp_d [8] = '{0, 78, 90, 90, 90, 90, 90, 90};
    en_cycle();
    vref = 10'd1000;
    for (int i = 0; i < 8; i++) begin
      sample(10'd0, lat);
      checks++;
      if (lat !== 3 || d_f !== 10'(exp_d[i])) begin
        failures++;
        $display("FAIL sat[%0d] lat=%0d d=%0d exp lat=3 d=%0d",
                 i, lat, d_f, exp_d[i]);
      end
    end
    vref = 10'd500;
    sample(10'd600, lat);
    checks++;
    if (d_f !== 10'd90) begin
      failures++;
      $display("FAIL windup_first got=%0d exp=90", d_f);
    end
    sample(10'd600, lat);
    checks++;
    if (d_f !== 10'd82) begin
      failures++;
      $display("FAIL windup_limit got=%0d exp=82", d_f);
    end
    for (int i = 0; i < 15; i++) begin
      sample(10'd999, lat);
      checks++;
      if (lat !== 3 || d_f > 10'd90) begin
        failures++;
        $display("FAIL unwind[%0d] lat=%0d d=%0d exp lat=3 d<=90",
                 i, lat, d_f);
      end
    end
    checks++;
    if (d_f !== 10'd0) begin
      failures++;
      $display("FAIL floor_d got=%0d exp=0", d_f);
    end
    sample(10'd400, lat);
    checks++;
    if (d_f !== 10'd7) begin
      failures++;
      $display("FAIL integ_nonneg got=%0d exp=7", d_f);
    end
  endtask

  task automatic test_soft_start();
    int exp_eff;
    en_cycle();
    vref = 10'd200;
    for (int n = 1; n <= 8; n++) begin
      strobe(10'd0);
      if (n == 2) begin
        vfb_valid = 1'b1;
        tick();
        vfb_valid = 1'b0;
        checks++;
        if (busy_s !== 1'b1) begin
          failures++;
          $display("FAIL soft_busy got=%b exp=1", busy_s);
        end
        repeat (2) tick();
      end else begin
        repeat (3) tick();
      end
      checks++;
      if (dv_s !== 1'b1) begin
        failures++;
        $display("FAIL soft_dv[%0d] got=%b exp=1", n, dv_s);
      end
      tick();
      exp_eff = n / 4;
      checks++;
      if (u_soft.vref_eff_q !== 10'(exp_eff) || dv_s !== 1'b0) begin
        failures++;
        $display("FAIL soft_eff[%0d] got=%0d dv=%b exp=%0d dv=0",
                 n, u_soft.vref_eff_q, dv_s, exp_eff);
      end
    end
  endtask

  task automatic test_ovp();
    checks++;
    if (d_f !== 10'd34) begin
      failures++;
      $display("FAIL ovp_pre_d got=%0d exp=34", d_f);
    end
    strobe(10'd1000);
    checks++;
    if (fault_f !== 1'b1 || d_f !== 10'd0 || dv_f !== 1'b1) begin
      failures++;
      $display("FAIL ovp_trip f=%b d=%0d dv=%b exp f=1 d=0 dv=1",
               fault_f, d_f, dv_f);
    end
    tick();
    checks++;
    if (dv_f !== 1'b0) begin
      failures++;
      $display("FAIL ovp_pulse got=%b exp=0", dv_f);
    end
    strobe(10'd100);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_f || dv_f || d_f !== 10'd0 || fault_f !== 1'b1) begin
        failures++;
        $display("FAIL ovp_ignore[%0d] b=%b dv=%b d=%0d f=%b", i,
                 busy_f, dv_f, d_f, fault_f);
      end
      tick();
    end
    en_cycle();
    checks++;
    if (fault_f !== 1'b0 || u_soft.vref_eff_q !== 10'd0) begin
      failures++;
      $display("FAIL ovp_clear f=%b eff=%0d exp f=0 eff=0",
               fault_f, u_soft.vref_eff_q);
    end
    strobe(10'd100);
    tick();
    strobe(10'd1000);
    checks++;
    if (fault_f !== 1'b1 || busy_f || dv_f !== 1'b1 || d_f !== 10'd0)
    begin
      failures++;
      $display("FAIL ovp_busy f=%b b=%b dv=%b d=%0d exp 1 0 1 0",
               fault_f, busy_f, dv_f, d_f);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dv_f !== 1'b0) begin
        failures++;
        $display("FAIL ovp_no_out[%0d] got=%b exp=0", i, dv_f);
      end
    end
    en_cycle();
  endtask

  task automatic test_en_drop();
    int lat;
    vref = 10'd200;
    sample(10'd100, lat);
    sample(10'd100, lat);
    checks++;
    if (d_f !== 10'd7) begin
      failures++;
      $display("FAIL en_pre_d got=%0d exp=7", d_f);
    end
    strobe(10'd100);
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (dv_f || d_f !== 10'd0 || busy_f || u_soft.busy_q ||
        u_fast.integ_q !== 24'd0) begin
      failures++;
      $display("FAIL en_drop dv=%b d=%0d b=%b integ=%0d exp 0 0 0 0",
               dv_f, d_f, busy_f, u_fast.integ_q);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dv_f !== 1'b0) begin
        failures++;
        $display("FAIL en_no_out[%0d] got=%b exp=0", i, dv_f);
      end
    end
    sample(10'd100, lat);
    checks++;
    if (lat !== 3 || d_f !== 10'd0) begin
      failures++;
      $display("FAIL en_resume lat=%0d d=%0d exp lat=3 d=0", lat, d_f);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pi();
    test_saturation();
    test_soft_start();
    test_ovp();
    test_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
